// File: rtl/game_pkg.sv
// Shared encodings and limits for the game controller.
// Holds state enum, key bit positions and counter saturation limits.
package game_pkg;

  typedef enum logic [1:0] {
    ST_TITLE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DEAD  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  localparam int NUM_KEYS    = 4;
  localparam int KEY_LEFT    = 0;
  localparam int KEY_RIGHT   = 1;
  localparam int KEY_JUMP    = 2;
  localparam int KEY_RESTART = 3;

  localparam logic [9:0]  PLAY_SEC_MAX = 10'd999;
  localparam logic [15:0] DEATH_MAX    = 16'hFFFF;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer plus rising-edge detect for the raw buttons.
// key_rise is high for one clk, two clks after the raw key rises; held keys give a single pulse.
module key_edge import game_pkg::*; (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] key_rise
);

  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] sync_q2;
  logic [NUM_KEYS-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      prev_q  <= '0;
    end else begin
      sync_q1 <= keys;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
    end
  end

  assign key_rise = sync_q2 & ~prev_q;

endmodule

// File: rtl/game_ctrl.sv
// Game flow controller: TITLE/PLAY/DEAD/CLEAR FSM with death, play-time and blink counters.
// Outputs registered; kid_hit/kid_at_goal act in 1 clk, keys in 3 clk (sync + edge).
module game_ctrl import game_pkg::*; #(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int MIN_DEAD_FRAMES = 32,
  parameter int BLINK_FRAMES    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [3:0]  keys,
  input  logic        kid_hit,
  input  logic        kid_at_goal,
  output logic [1:0]  game_state,
  output logic        play_en,
  output logic        respawn,
  output logic        overlay_en,
  output logic [15:0] death_cnt,
  output logic [9:0]  play_sec
);

  localparam int DIV_W   = cnt_width(FRAMES_PER_SEC);
  localparam int DEAD_W  = cnt_width(MIN_DEAD_FRAMES + 1);
  localparam int BLINK_W = cnt_width(BLINK_FRAMES);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FRAMES_PER_SEC - 1);
  localparam logic [DEAD_W-1:0]  DEAD_FULL  = DEAD_W'(MIN_DEAD_FRAMES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  state_t              state;
  state_t              next_state;
  logic [3:0]          key_rise;
  logic                any_rise;
  logic                restart_rise;
  logic                enter_play;
  logic                enter_dead;
  logic                series_reset;
  logic                dead_tick;
  logic [DIV_W-1:0]    frame_div;
  logic [DEAD_W-1:0]   dead_frames;
  logic [BLINK_W-1:0]  blink_cnt;

  key_edge u_key_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .keys     (keys),
    .key_rise (key_rise)
  );

  assign any_rise     = key_rise[KEY_LEFT] | key_rise[KEY_RIGHT] |
                        key_rise[KEY_JUMP] | key_rise[KEY_RESTART];
  assign restart_rise = key_rise[KEY_RESTART];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_TITLE;
    else        state <= next_state;
  end

  // Overlap flags are ignored while respawn is high: they still reflect the pre-respawn position.
  always_comb begin
    next_state = state;
    case (state)
      ST_TITLE: if (any_rise) next_state = ST_PLAY;
      ST_PLAY: begin
        if (!respawn) begin
          if (kid_hit)          next_state = ST_DEAD;
          else if (kid_at_goal) next_state = ST_CLEAR;
        end
      end
      ST_DEAD:  if (restart_rise && dead_frames == DEAD_FULL) next_state = ST_PLAY;
      ST_CLEAR: if (restart_rise) next_state = ST_TITLE;
      default:  next_state = ST_TITLE;
    endcase
  end

  assign enter_play   = (next_state == ST_PLAY) && (state != ST_PLAY);
  assign enter_dead   = (next_state == ST_DEAD) && (state != ST_DEAD);
  assign series_reset = (state == ST_CLEAR) && (next_state == ST_TITLE);
  assign dead_tick    = frame_tick && (state == ST_DEAD) && (next_state == ST_DEAD);
  assign game_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_en     <= 1'b0;
      respawn     <= 1'b0;
      overlay_en  <= 1'b0;
      death_cnt   <= '0;
      play_sec    <= '0;
      frame_div   <= '0;
      dead_frames <= '0;
      blink_cnt   <= '0;
    end else begin
      play_en <= (next_state == ST_PLAY);
      respawn <= enter_play;

      if (series_reset)
        death_cnt <= '0;
      else if (enter_dead && death_cnt != DEATH_MAX)
        death_cnt <= death_cnt + 16'd1;

      // A tick on a transition edge belongs to the state being entered.
      if (series_reset) begin
        frame_div <= '0;
        play_sec  <= '0;
      end else if (frame_tick && next_state == ST_PLAY) begin
        if (frame_div == DIV_LAST) begin
          frame_div <= '0;
          if (play_sec != PLAY_SEC_MAX) play_sec <= play_sec + 10'd1;
        end else begin
          frame_div <= frame_div + DIV_W'(1);
        end
      end

      if (enter_dead) begin
        dead_frames <= DEAD_W'(frame_tick);
        blink_cnt   <= BLINK_W'(frame_tick);
      end else if (dead_tick) begin
        if (dead_frames != DEAD_FULL) dead_frames <= dead_frames + DEAD_W'(1);
        if (blink_cnt == BLINK_LAST) blink_cnt <= '0;
        else                         blink_cnt <= blink_cnt + BLINK_W'(1);
      end

      if (next_state == ST_CLEAR)
        overlay_en <= 1'b1;
      else if (next_state != ST_DEAD)
        overlay_en <= 1'b0;
      else if (enter_dead)
        overlay_en <= 1'b1;
      else if (dead_tick && blink_cnt == BLINK_LAST)
        overlay_en <= ~overlay_en;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: table of TITLE key vectors plus hand-written flow sequences.
// Expected outputs are queued when stimulus is applied and compared when the DUT settles.
module tb_game_ctrl;
  import game_pkg::*;

  typedef struct packed {
    logic [1:0]  st;
    logic        pe;
    logic        rs;
    logic        ov;
    logic [15:0] dc;
    logic [9:0]  ps;
  } out_t;

  typedef struct {
    logic [3:0] keys;
    out_t       exp3;
    out_t       exp4;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic [3:0]  keys;
  logic        kid_hit;
  logic        kid_at_goal;
  logic [1:0]  game_state;
  logic        play_en;
  logic        respawn;
  logic        overlay_en;
  logic [15:0] death_cnt;
  logic [9:0]  play_sec;

  int checks = 0;
  int errors = 0;
  out_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[5];

  game_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .keys        (keys),
    .kid_hit     (kid_hit),
    .kid_at_goal (kid_at_goal),
    .game_state  (game_state),
    .play_en     (play_en),
    .respawn     (respawn),
    .overlay_en  (overlay_en),
    .death_cnt   (death_cnt),
    .play_sec    (play_sec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not reach its end, got timeout, required completion");
    $fatal(1, "watchdog timeout");
  end

  function automatic out_t mk(input logic [1:0] st, input logic pe, input logic rs,
                              input logic ov, input logic [15:0] dc, input logic [9:0] ps);
    out_t o;
    o.st = st; o.pe = pe; o.rs = rs; o.ov = ov; o.dc = dc; o.ps = ps;
    return o;
  endfunction

  function automatic out_t observed();
    return mk(game_state, play_en, respawn, overlay_en, death_cnt, play_sec);
  endfunction

  task automatic exp_push(input string name, input out_t e);
    name_q.push_back(name);
    exp_q.push_back(e);
  endtask

  task automatic compare();
    out_t  e;
    out_t  a;
    string n;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expectation, required one queued");
      return;
    end
    e = exp_q.pop_front();
    n = name_q.pop_front();
    a = observed();
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d pe=%0b rs=%0b ov=%0b deaths=%0d sec=%0d, required st=%0d pe=%0b rs=%0b ov=%0b deaths=%0d sec=%0d",
               n, a.st, a.pe, a.rs, a.ov, a.dc, a.ps, e.st, e.pe, e.rs, e.ov, e.dc, e.ps);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    keys = 4'd0; kid_hit = 1'b0; kid_at_goal = 1'b0; frame_tick = 1'b0;
    #2;
    exp_push("reset_state", mk(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0));
    compare();
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; keys = 4'd0; kid_hit = 1'b0; kid_at_goal = 1'b0; frame_tick = 1'b0;

    // TITLE: any key edge enters PLAY three clocks later with a single respawn cycle.
    vecs[0] = '{4'b0001, mk(2'd1, 1'b1, 1'b1, 1'b0, 16'd0, 10'd0), mk(2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 10'd0)};
    vecs[1] = '{4'b0010, mk(2'd1, 1'b1, 1'b1, 1'b0, 16'd0, 10'd0), mk(2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 10'd0)};
    vecs[2] = '{4'b0100, mk(2'd1, 1'b1, 1'b1, 1'b0, 16'd0, 10'd0), mk(2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 10'd0)};
    vecs[3] = '{4'b1000, mk(2'd1, 1'b1, 1'b1, 1'b0, 16'd0, 10'd0), mk(2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 10'd0)};
    vecs[4] = '{4'b0000, mk(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0), mk(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0)};

    for (int i = 0; i < 5; i++) begin
      do_reset();
      keys = vecs[i].keys;
      exp_push($sformatf("title_vec%0d_t2", i), mk(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0));
      cyc(2);
      compare();
      exp_push($sformatf("title_vec%0d_t3", i), vecs[i].exp3);
      cyc(1);
      compare();
      exp_push($sformatf("title_vec%0d_t4", i), vecs[i].exp4);
      cyc(1);
      compare();
      keys = 4'd0;
    end

    // Main flow: play time, hit+goal priority, DEAD lockout and blink, CLEAR back to TITLE.
    do_reset();
    keys = 4'b0100;
    exp_push("jump_to_play", mk(2'd1, 1'b1, 1'b1, 1'b0, 16'd0, 10'd0));
    cyc(3);
    compare();
    keys = 4'd0;
    exp_push("respawn_one_cycle", mk(2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 10'd0));
    cyc(1);
    compare();

    exp_push("play_59_ticks", mk(2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 10'd0));
    repeat (59) tick();
    compare();
    exp_push("play_60_ticks", mk(2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 10'd1));
    tick();
    compare();
    exp_push("play_120_ticks", mk(2'd1, 1'b1, 1'b0, 1'b0, 16'd0, 10'd2));
    repeat (60) tick();
    compare();

    kid_hit = 1'b1; kid_at_goal = 1'b1;
    exp_push("hit_wins_over_goal", mk(2'd2, 1'b0, 1'b0, 1'b1, 16'd1, 10'd2));
    cyc(1);
    compare();
    kid_at_goal = 1'b0;
    exp_push("hit_ignored_in_dead", mk(2'd2, 1'b0, 1'b0, 1'b1, 16'd1, 10'd2));
    cyc(1);
    compare();
    kid_hit = 1'b0;

    repeat (10) tick();
    keys = 4'b1000;
    exp_push("early_restart_ignored", mk(2'd2, 1'b0, 1'b0, 1'b1, 16'd1, 10'd2));
    cyc(3);
    compare();
    keys = 4'd0;
    cyc(3);

    for (int f = 11; f <= 60; f++) begin
      if (f == 15 || f == 16 || f == 31 || f == 32 || f == 47 || f == 48 || f == 60)
        exp_push($sformatf("dead_frame%0d", f),
                 mk(2'd2, 1'b0, 1'b0, ((f / 16) % 2) == 0, 16'd1, 10'd2));
      tick();
      if (f == 15 || f == 16 || f == 31 || f == 32 || f == 47 || f == 48 || f == 60)
        compare();
    end

    keys = 4'b1000;
    exp_push("restart_after_min_frames", mk(2'd1, 1'b1, 1'b1, 1'b0, 16'd1, 10'd2));
    cyc(3);
    compare();
    keys = 4'd0;
    kid_hit = 1'b1;
    exp_push("stale_hit_in_respawn", mk(2'd1, 1'b1, 1'b0, 1'b0, 16'd1, 10'd2));
    cyc(1);
    compare();
    kid_hit = 1'b0;

    kid_at_goal = 1'b1;
    exp_push("goal_to_clear", mk(2'd3, 1'b0, 1'b0, 1'b1, 16'd1, 10'd2));
    cyc(1);
    compare();
    kid_at_goal = 1'b0;
    exp_push("clear_frozen", mk(2'd3, 1'b0, 1'b0, 1'b1, 16'd1, 10'd2));
    repeat (3) tick();
    compare();

    keys = 4'b1000;
    exp_push("clear_restart_title", mk(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0));
    cyc(3);
    compare();
    exp_push("held_key_no_retrigger", mk(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0));
    cyc(5);
    compare();
    keys = 4'd0;
    cyc(3);

    // Reset in the middle of DEAD after five deaths.
    do_reset();
    keys = 4'b0100;
    cyc(3);
    keys = 4'd0;
    cyc(1);
    for (int i = 1; i <= 5; i++) begin
      kid_hit = 1'b1;
      cyc(1);
      kid_hit = 1'b0;
      if (i < 5) begin
        repeat (32) tick();
        keys = 4'b1000;
        cyc(3);
        keys = 4'd0;
        cyc(1);
      end
    end
    exp_push("five_deaths", mk(2'd2, 1'b0, 1'b0, 1'b1, 16'd5, 10'd0));
    compare();
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    exp_push("async_reset_mid_dead", mk(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0));
    #1;
    compare();
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_push($sformatf("post_reset_idle%0d", i), mk(2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 10'd0));
      cyc(1);
      compare();
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d unchecked entries, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter FRAMES_PER_SEC, default 60, frame_tick pulses per play-time second.
REQ-002 Parameter MIN_DEAD_FRAMES, default 32, frames in DEAD before restart is accepted.
REQ-003 Parameter BLINK_FRAMES, default 16, frames per overlay blink half-period in DEAD.
REQ-004 clk  in  1  system clock; one clock domain, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame (vsync-derived, clk domain).
REQ-007 keys  in  4  raw buttons, active-high; [0] left, [1] right, [2] jump, [3] restart.
REQ-008 kid_hit  in  1  level; OR of all apple/kid overlap flags.
REQ-009 kid_at_goal  in  1  level; kid inside goal region.
REQ-010 game_state  out  2  TITLE=0, PLAY=1, DEAD=2, CLEAR=3.
REQ-011 play_en  out  1  gates kid/apple/cloud position updates; high only in PLAY.
REQ-012 respawn  out  1  one-cycle pulse; returns kid and apples to initial positions.
REQ-013 overlay_en  out  1  selects "game over"/"clear" text layer in the renderer.
REQ-014 death_cnt  out  16  total deaths since reset, binary.
REQ-015 play_sec  out  10  elapsed play seconds of current attempt series.

Function
REQ-016 keys SHALL pass a 2-flop synchronizer, then a rising-edge detector; only edges (key_rise[3:0]) drive transitions; held keys SHALL NOT retrigger.
REQ-017 TITLE: any key_rise bit -> PLAY next edge; respawn SHALL be high exactly in the first PLAY cycle.
REQ-018 PLAY: kid_hit=1 -> DEAD, death_cnt+1 same edge; kid_at_goal=1 -> CLEAR; both simultaneously -> DEAD (hit wins).
REQ-019 death_cnt SHALL saturate at 16'hFFFF.
REQ-020 DEAD: dead_frames counter SHALL clear on entry and count frame_tick, saturating at MIN_DEAD_FRAMES.
REQ-021 DEAD: key_rise[3] with dead_frames==MIN_DEAD_FRAMES -> PLAY with respawn pulse; earlier restart edges SHALL be ignored (not queued).
REQ-022 CLEAR: key_rise[3] -> TITLE; play_sec and death_cnt SHALL clear to 0 on that edge.
REQ-023 play_sec: sub-counter counts frame_tick only while in PLAY; at FRAMES_PER_SEC-1 it wraps to 0 and play_sec increments, saturating at 999; frozen (not cleared) in DEAD/CLEAR.
REQ-024 overlay_en: 0 in TITLE/PLAY; 1 on DEAD entry, toggling every BLINK_FRAMES frame_ticks; steady 1 in CLEAR.
REQ-025 play_en SHALL equal (game_state==PLAY) registered, no combinational path from inputs.
REQ-026 kid_hit/kid_at_goal SHALL be ignored outside PLAY and in the respawn cycle (stale overlap from pre-respawn position).
REQ-027 frame_tick coinciding with a transition SHALL be counted by the state being entered only if that state counts frames on the following tick; no double count.
REQ-028 All outputs registered; input-to-state latency 1 clk for kid_hit/kid_at_goal, 3 clk for keys (sync + edge).

Reset
REQ-029 rst_n low SHALL asynchronously force game_state=TITLE, play_en=0, respawn=0, overlay_en=0, death_cnt=0, play_sec=0, all internal counters and synchronizer flops 0.
REQ-030 Reset asserted mid-PLAY/DEAD SHALL discard in-progress counts; release resumes in TITLE without a respawn pulse.

Structure
REQ-031 Shared package game_pkg SHALL hold state encodings, key index constants (KEY_LEFT..KEY_RESTART) and play_sec saturation limit 999.
REQ-032 Sub-module key_edge (4-bit synchronizer + rising-edge detect) SHALL be instantiated once; remainder is one FSM plus counters.

Verification
REQ-033 Reset, press keys[2] in TITLE -> game_state=1 after 3 clk, respawn high 1 cycle, play_en=1.
REQ-034 PLAY, assert kid_hit and kid_at_goal same cycle -> game_state=2, death_cnt=1, overlay_en=1.
REQ-035 DEAD, restart at frame 10 -> ignored; restart at frame 32 -> PLAY, respawn pulse, play_sec unchanged.
REQ-036 PLAY for 120 frame_ticks -> play_sec=2; 60 more in DEAD -> play_sec still 2; overlay_en toggles at frames 16, 32, 48.
REQ-037 kid_at_goal -> CLEAR, overlay_en=1; restart -> TITLE, death_cnt=0, play_sec=0.
REQ-038 rst_n low mid-DEAD with death_cnt=5 -> all outputs 0 immediately, game_state=0, no respawn after release.
